alu_rr_scheduler: RTL and testbench

//   Shares one combinational 8-bit ALU core (add/sub/and/or) between two requesters.

---
 rtl/alu_sched_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 18 +
 rtl/alu_rr_scheduler.sv | 158 +++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared definitions for the two-requester ALU scheduler.
//   - DATA_W_DEF / OP_W_DEF : default operand and opcode widths
//   - OP_ADD/OP_SUB/OP_AND/OP_OR : opcode encodings (all others give result 0)
//   - state_e : scheduler FSM states ST_IDLE/ST_EXEC/ST_RESP
package alu_sched_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int OP_W_DEF   = 4;

  localparam logic [OP_W_DEF-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W_DEF-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W_DEF-1:0] OP_AND = 4'd2;
  localparam logic [OP_W_DEF-1:0] OP_OR  = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter (purely combinational).
//   req_valid [1:0] : request vector, bit i = requester i
//   last_grant      : index of the requester granted most recently
//   grant     [1:0] : one-hot grant, 0 when nothing requests
// A lone request wins outright; on a tie the requester that did not win
// last time is granted, so neither side can be starved.
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = req_valid;
    if (&req_valid) grant = last_grant ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one combinational add/sub/and/or ALU between two requesters.
// Round-robin accepts one request in IDLE, executes it for one cycle
// (EXEC) and presents a tagged result (RESP) until resp_ready.
//   clock, reset          : rising-edge clock, async active-low reset
//   req_valid[1:0]        : per-requester valid
//   req_op0/1, a0/1, b0/1 : per-requester opcode and operands
//   req_ready[1:0]        : one-hot accept (only in IDLE)
//   resp_valid/id/data    : result channel, held until resp_ready
//   busy                  : FSM not in IDLE
// Optional feature macro ALU_SCHED_FLAGS_EN adds resp_zero and resp_carry
// (ADD carry-out / SUB borrow), registered alongside resp_data.
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  input  logic [OP_W-1:0]   req_op0,
  input  logic [OP_W-1:0]   req_op1,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_b1,
  output logic [1:0]        req_ready,
  output logic              resp_valid,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_data,
  input  logic              resp_ready,
  output logic              busy
`ifdef ALU_SCHED_FLAGS_EN
  ,
  output logic              resp_zero,
  output logic              resp_carry
`endif
);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              last_grant_q, last_grant_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_id_q, resp_id_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic [1:0]        grant;
  logic [DATA_W:0]   alu_wide;  // top bit = ADD carry-out / SUB borrow

  rr_arb2 u_arb (
    .req_valid (req_valid),
    .last_grant(last_grant_q),
    .grant     (grant)
  );

  assign req_ready = (state_q == ST_IDLE) ? grant : 2'b00;

  always_comb begin
    case (op_q)
      OP_W'(OP_ADD): alu_wide = {1'b0, a_q} + {1'b0, b_q};
      OP_W'(OP_SUB): alu_wide = {1'b0, a_q} - {1'b0, b_q};
      OP_W'(OP_AND): alu_wide = {1'b0, a_q & b_q};
      OP_W'(OP_OR):  alu_wide = {1'b0, a_q | b_q};
      default:       alu_wide = '0;
    endcase
  end

`ifdef ALU_SCHED_FLAGS_EN
  logic zero_q, zero_d, carry_q, carry_d;
`else
  logic unused_carry;
  assign unused_carry = alu_wide[DATA_W];
`endif

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    last_grant_d = last_grant_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
`ifdef ALU_SCHED_FLAGS_EN
    zero_d       = zero_q;
    carry_d      = carry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req_ready) begin
          // grant is one-hot, so bit 1 alone identifies the winner
          op_d         = req_ready[1] ? req_op1 : req_op0;
          a_d          = req_ready[1] ? req_a1  : req_a0;
          b_d          = req_ready[1] ? req_b1  : req_b0;
          last_grant_d = req_ready[1];
          resp_id_d    = req_ready[1];
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        resp_data_d  = alu_wide[DATA_W-1:0];
        resp_valid_d = 1'b1;
`ifdef ALU_SCHED_FLAGS_EN
        zero_d       = (alu_wide[DATA_W-1:0] == '0);
        carry_d      = alu_wide[DATA_W];
`endif
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      last_grant_q <= 1'b1;  // requester 0 wins the first tie
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
`ifdef ALU_SCHED_FLAGS_EN
      zero_q       <= 1'b0;
      carry_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      last_grant_q <= last_grant_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
`ifdef ALU_SCHED_FLAGS_EN
      zero_q       <= zero_d;
      carry_q      <= carry_d;
`endif
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign busy       = (state_q != ST_IDLE);
`ifdef ALU_SCHED_FLAGS_EN
  assign resp_zero  = zero_q;
  assign resp_carry = carry_q;
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler: a vector table of single-requester
// operations plus hand-written tie, back-pressure and mid-op reset sequences.
// Honours ALU_SCHED_FLAGS_EN for the zero/carry outputs.
module tb_alu_rr_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] req_valid;
  logic [3:0] req_op0, req_op1;
  logic [7:0] req_a0, req_a1, req_b0, req_b1;
  logic [1:0] req_ready;
  logic       resp_valid, resp_id, resp_ready, busy;
  logic [7:0] resp_data;
`ifdef ALU_SCHED_FLAGS_EN
  logic       resp_zero, resp_carry;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  alu_rr_scheduler dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op0   (req_op0),
    .req_op1   (req_op1),
    .req_a0    (req_a0),
    .req_a1    (req_a1),
    .req_b0    (req_b0),
    .req_b1    (req_b1),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_id   (resp_id),
    .resp_data (resp_data),
    .resp_ready(resp_ready),
    .busy      (busy)
`ifdef ALU_SCHED_FLAGS_EN
    ,
    .resp_zero (resp_zero),
    .resp_carry(resp_carry)
`endif
  );

  typedef struct {
    logic       id;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
    logic       zero;
    logic       carry;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic set_req(input logic id, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    if (id) begin req_op1 = op; req_a1 = a; req_b1 = b; end
    else    begin req_op0 = op; req_a0 = a; req_b0 = b; end
  endtask

  // One isolated transaction: accept, EXEC, RESP, consume.
  task automatic run_op(input vec_t v);
    @(negedge clock);
    set_req(v.id, v.op, v.a, v.b);
    req_valid = v.id ? 2'b10 : 2'b01;
    #1 chk("ready_grant", 32'(req_ready), v.id ? 32'h2 : 32'h1);
    @(posedge clock); #1;
    req_valid = 2'b00;
    chk("exec_busy", 32'(busy), 1);
    chk("exec_no_valid", 32'(resp_valid), 0);
    @(posedge clock); #1;
    chk("resp_valid", 32'(resp_valid), 1);
    chk("resp_id", 32'(resp_id), 32'(v.id));
    chk("resp_data", 32'(resp_data), 32'(v.exp));
`ifdef ALU_SCHED_FLAGS_EN
    chk("resp_zero", 32'(resp_zero), 32'(v.zero));
    chk("resp_carry", 32'(resp_carry), 32'(v.carry));
`endif
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    chk("resp_drop", 32'(resp_valid), 0);
    chk("idle_again", 32'(busy), 0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 4'd0, 8'd200, 8'd100, 8'd44,  1'b0, 1'b1};
    vecs[1] = '{1'b1, 4'd1, 8'd1,   8'd2,   8'hFF,  1'b0, 1'b1};
    vecs[2] = '{1'b0, 4'd7, 8'd5,   8'd3,   8'h00,  1'b1, 1'b0};
    vecs[3] = '{1'b1, 4'd2, 8'hAA,  8'h0F,  8'h0A,  1'b0, 1'b0};
    vecs[4] = '{1'b0, 4'd3, 8'h0F,  8'hF0,  8'hFF,  1'b0, 1'b0};
    vecs[5] = '{1'b1, 4'd1, 8'd3,   8'd3,   8'h00,  1'b1, 1'b0};
    vecs[6] = '{1'b0, 4'd0, 8'hFF,  8'h01,  8'h00,  1'b1, 1'b1};
    vecs[7] = '{1'b1, 4'd1, 8'h10,  8'h01,  8'h0F,  1'b0, 1'b0};
    vecs[8] = '{1'b0, 4'd15, 8'hAA, 8'h55,  8'h00,  1'b1, 1'b0};

    reset = 1'b0; req_valid = 2'b00; resp_ready = 1'b0;
    req_op0 = '0; req_op1 = '0; req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;

    // Reset state
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_id", 32'(resp_id), 0);
    chk("rst_resp_data", 32'(resp_data), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
`ifdef ALU_SCHED_FLAGS_EN
    chk("rst_zero", 32'(resp_zero), 0);
    chk("rst_carry", 32'(resp_carry), 0);
`endif
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    repeat (2) begin
      @(posedge clock); #1;
      chk("idle_no_req_busy", 32'(busy), 0);
      chk("idle_no_req_ready", 32'(req_ready), 0);
    end

    // Table of isolated operations
    for (int i = 0; i < 9; i++) run_op(vecs[i]);

    // Re-establish a known last_grant (=1) before the tie sequence
    reset = 1'b0; #1; reset = 1'b1;

    // Tie: req0 SUB 1-2 vs req1 OR 0F|F0; req0 wins first
    @(negedge clock);
    set_req(1'b0, 4'd1, 8'd1, 8'd2);
    set_req(1'b1, 4'd3, 8'h0F, 8'hF0);
    req_valid = 2'b11;
    #1 chk("tie1_grant", 32'(req_ready), 32'h1);
    @(posedge clock); #1;
    req_valid = 2'b10;
    chk("tie1_exec_ready", 32'(req_ready), 0);
    @(posedge clock); #1;
    chk("tie1_resp_id", 32'(resp_id), 0);
    chk("tie1_resp_data", 32'(resp_data), 32'hFF);
    resp_ready = 1'b1;
    req_valid  = 2'b11;  // req0 asks again: tie must now go to req1
    @(posedge clock); #1;
    resp_ready = 1'b0;
    chk("tie2_grant", 32'(req_ready), 32'h2);
    @(posedge clock); #1;
    req_valid = 2'b01;
    @(posedge clock); #1;
    chk("tie2_resp_valid", 32'(resp_valid), 1);
    chk("tie2_resp_id", 32'(resp_id), 1);
    chk("tie2_resp_data", 32'(resp_data), 32'hFF);

    // Back-pressure: result held for 5 cycles, new requests ignored
    req_valid = 2'b11;
    repeat (5) begin
      @(posedge clock); #1;
      chk("hold_valid", 32'(resp_valid), 1);
      chk("hold_id", 32'(resp_id), 1);
      chk("hold_data", 32'(resp_data), 32'hFF);
      chk("hold_ready", 32'(req_ready), 0);
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    chk("tie3_grant", 32'(req_ready), 32'h1);  // req1 won last, req0 now
    @(posedge clock); #1;
    req_valid = 2'b00;
    @(posedge clock); #1;
    chk("tie3_resp_id", 32'(resp_id), 0);
    chk("tie3_resp_data", 32'(resp_data), 32'hFF);
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    chk("tie3_idle", 32'(busy), 0);

    // Reset pulsed during EXEC: operation discarded
    @(negedge clock);
    set_req(1'b0, 4'd0, 8'd5, 8'd6);
    req_valid = 2'b01;
    @(posedge clock); #1;
    req_valid = 2'b00;
    chk("mid_exec_busy", 32'(busy), 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_valid", 32'(resp_valid), 0);
    chk("mid_rst_data", 32'(resp_data), 0);
    @(negedge clock); reset = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
      chk("post_rst_no_resp", 32'(resp_valid), 0);
    end
    run_op('{1'b1, 4'd0, 8'd5, 8'd6, 8'd11, 1'b0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
